branch_predictor_unit: RTL
==========================

Name: branch_predictor_unit

Overview:
- Dynamic branch predictor and redirect controller for the 5-stage pipeline.
- In Fetch: predicts taken/not-taken and target for conditional branches and JAL, using a direct-mapped BTB with 2-bit saturating counters.
- In Execute: compares the resolved outcome (PCSrcE) against the prediction carried down the pipe, updates the table, and raises redirect/flush with the corrected PC.
- Keeps wrapping performance counters for branches and mispredicts.

Parameters:
- INDEX_BITS, 4, BTB index width; entries = 2**INDEX_BITS, indexed by PC[INDEX_BITS+1:2]
- XLEN, 32, PC and target width
- TAG_BITS, XLEN-INDEX_BITS-2, tag taken from PC[XLEN-1:INDEX_BITS+2]

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- pcF  in  XLEN  Fetch-stage PC
- predTakenF  out  1  Fetch prediction: taken
- predTargetF  out  XLEN  predicted target; PCF+4 when predTakenF=0
- validE  in  1  Execute stage holds a real instruction (0 for bubble/flushed)
- pcE  in  XLEN  Execute-stage PC
- branchE  in  3  branch type: 000 general/none, 001 BEQ, 010 BNE
- jumpE  in  2  jump type: 00 none, 01 JAL, 10 JALR
- PCSrcE  in  2  resolved next-PC select: 00 PC+4, 01 PC-relative target, 10 JALR target
- targetE  in  XLEN  resolved target (branch/JAL adder or JALR ALU result)
- predTakenE  in  1  predTakenF piped to Execute
- predTargetE  in  XLEN  predTargetF piped to Execute
- redirectE  out  1  mispredict: flush D and E, load redirectPCE
- redirectPCE  out  XLEN  corrected fetch PC
- branchCount  out  32  resolved conditional branches + JAL + JALR
- mispredCount  out  32  number of redirectE assertions

Behaviour:
- Entry fields: valid, tag, target, ctr[1:0].
- Reset (synchronous, rst=1 at posedge): every entry valid=0, ctr=01, tag/target=0; both counters=0. rst overrides any same-cycle update.
- Fetch lookup, combinational (zero latency):
  - hit = valid && tag==pcF tag.
  - predTakenF = hit && ctr[1].
  - predTargetF = predTakenF ? target : pcF+4.
- Fetch reads pre-edge state: a same-cycle E update to the same index is not visible in F until the next cycle (read-before-write).
- Resolution is "active" when validE=1 and the instruction is BEQ, BNE, JAL or JALR. When validE=0 or not a branch/jump: redirectE=0, no update, counters hold.
- actualTaken = (PCSrcE != 00).
- redirectE (combinational from E inputs):
  - JALR: asserted iff !predTakenE or predTargetE != targetE. JALR is never allocated, so normally always asserted.
  - Others: asserted iff predTakenE != actualTaken, or (actualTaken && predTargetE != targetE).
- redirectPCE = actualTaken ? targetE : pcE+4. It is defined (this value) even when redirectE=0.
- Table update at posedge, active BEQ/BNE/JAL only:
  - Hit: ctr saturating +1 if taken (11 stays 11), -1 if not (00 stays 00); target overwritten with targetE when taken.
  - Miss, taken: allocate valid=1, tag, target=targetE, ctr=10 (weakly taken), replacing any occupant.
  - Miss, not taken: no change.
- JALR never writes the table.
- Counters, at posedge:
  - branchCount += 1 per active resolution.
  - mispredCount += 1 per redirectE.
  - Both wrap FFFF_FFFF -> 0.
- One resolution per cycle. No stall input: the upstream pipeline holds validE=0 for stalled or duplicated E occupancy.
- Reset mid-operation: a pending E resolution is discarded; the post-reset lookup misses everywhere.

Decomposition:
- Package bp_pkg holds:
  - Branch encodings: GENERAL_JUMP=3'b000, BEQ=3'b001, BNE=3'b010.
  - Jump encodings: JUMP_NONE=2'b00, JAL=2'b01, JALR=2'b10.
  - PCSrc encodings: PC_PLUS4=2'b00, PC_TARGET=2'b01, PC_JALR=2'b10.
  - ctr_t enum: STRONG_NT=00, WEAK_NT=01, WEAK_T=10, STRONG_T=11.
  - btb_entry_t struct.
- Sub-module bp_sat_counter: combinational 2-bit saturating next-state from (ctr, taken).

Test Plan:
- Reset, then pcF=0x40 -> predTakenF=0, predTargetF=0x44; branchCount=mispredCount=0.
- BEQ at pcE=0x40, PCSrcE=01, targetE=0x80, predTakenE=0 -> redirectE=1, redirectPCE=0x80; next cycle pcF=0x40 gives predTakenF=1, predTargetF=0x80, mispredCount=1.
- Same BEQ resolved not-taken twice (PCSrcE=00, predTakenE=1, then 0) -> ctr 10->01->00; first gives redirectE=1, redirectPCE=0x44; second gives redirectE=0; pcF=0x40 then predicts not-taken.
- JALR at pcE=0x20, PCSrcE=10, targetE=0x100 -> redirectE=1, redirectPCE=0x100; table unchanged (pcF=0x20 misses).
- Aliasing: BNE at 0x40 taken to 0x80, then BNE at 0x80 (same index, INDEX_BITS=4) taken to 0xC0 -> entry replaced; pcF=0x40 misses, pcF=0x80 predicts 0xC0.
- Update while validE=0 with PCSrcE=01 -> no redirect, no counter change. rst asserted in same cycle as an active resolution -> table cleared, counters 0.

Source files
------------

// File: rtl/bp_pkg.sv
// bp_pkg: shared encodings and BTB entry layout for the branch predictor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: branch/jump/PCSrc encodings, ctr_t saturating-counter states,
//           btb_entry_t (valid, tag, target, ctr) sized from the default widths.
package bp_pkg;

  // Default geometry. The top-level parameters default to these values, and
  // btb_entry_t is laid out from them.
  localparam int BP_XLEN       = 32;
  localparam int BP_INDEX_BITS = 4;
  localparam int BP_TAG_BITS   = BP_XLEN - BP_INDEX_BITS - 2;

  // branchE encodings
  localparam logic [2:0] GENERAL_JUMP = 3'b000;
  localparam logic [2:0] BEQ          = 3'b001;
  localparam logic [2:0] BNE          = 3'b010;

  // jumpE encodings
  localparam logic [1:0] JUMP_NONE = 2'b00;
  localparam logic [1:0] JAL       = 2'b01;
  localparam logic [1:0] JALR      = 2'b10;

  // PCSrcE encodings
  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_TARGET = 2'b01;
  localparam logic [1:0] PC_JALR   = 2'b10;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } ctr_t;

  typedef struct packed {
    logic                   valid;
    logic [BP_TAG_BITS-1:0] tag;
    logic [BP_XLEN-1:0]     target;
    ctr_t                   ctr;
  } btb_entry_t;

endpackage

// File: rtl/bp_sat_counter.sv
// bp_sat_counter: next state of a 2-bit saturating taken/not-taken counter.
// Latency: combinational.
// Backpressure: none.
// Ports: ctr_i current state, taken_i resolved direction, ctr_o next state.
module bp_sat_counter
  import bp_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       taken_i,
  output logic [1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (taken_i) begin
      if (ctr_i != STRONG_T) ctr_o = ctr_i + 2'd1;
    end else begin
      if (ctr_i != STRONG_NT) ctr_o = ctr_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor_unit.sv
// branch_predictor_unit: direct-mapped BTB + 2-bit counters; Fetch prediction, Execute redirect.
// Latency: Fetch lookup and Execute redirect are combinational; table/counters update at posedge.
// Backpressure: none; one resolution per cycle, upstream drops validE for stalls/bubbles.
// Ports: clk/rst (sync, active-high); pcF -> predTakenF/predTargetF;
//        validE, pcE, branchE, jumpE, PCSrcE, targetE, predTakenE, predTargetE
//        -> redirectE/redirectPCE; branchCount/mispredCount wrapping counters.
module branch_predictor_unit
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = BP_INDEX_BITS,
  parameter int XLEN       = BP_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pcF,
  output logic            predTakenF,
  output logic [XLEN-1:0] predTargetF,
  input  logic            validE,
  input  logic [XLEN-1:0] pcE,
  input  logic [2:0]      branchE,
  input  logic [1:0]      jumpE,
  input  logic [1:0]      PCSrcE,
  input  logic [XLEN-1:0] targetE,
  input  logic            predTakenE,
  input  logic [XLEN-1:0] predTargetE,
  output logic            redirectE,
  output logic [XLEN-1:0] redirectPCE,
  output logic [31:0]     branchCount,
  output logic [31:0]     mispredCount
);

  localparam int TAG_BITS = XLEN - INDEX_BITS - 2;
  localparam int ENTRIES  = 2 ** INDEX_BITS;

  btb_entry_t btb_q [ENTRIES];
  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;

  // ---------------- Fetch lookup (reads pre-edge table state) ----------------
  logic [INDEX_BITS-1:0] idx_f;
  logic [TAG_BITS-1:0]   tag_f;
  btb_entry_t            entry_f;
  logic                  hit_f;

  assign idx_f   = pcF[INDEX_BITS+1:2];
  assign tag_f   = pcF[XLEN-1:INDEX_BITS+2];
  assign entry_f = btb_q[idx_f];
  assign hit_f   = entry_f.valid && (entry_f.tag == tag_f);

  assign predTakenF  = hit_f && entry_f.ctr[1];
  assign predTargetF = predTakenF ? entry_f.target : pcF + XLEN'(4);

  // ---------------- Execute resolution ----------------
  logic is_cond, is_jal, is_jalr, is_none, active, actual_taken, mispred;

  assign is_cond      = (branchE == BEQ) || (branchE == BNE);
  assign is_jal       = (jumpE == JAL);
  assign is_jalr      = (jumpE == JALR);
  assign is_none      = (branchE == GENERAL_JUMP) && (jumpE == JUMP_NONE);
  assign active       = validE && !is_none && (is_cond || is_jal || is_jalr);
  assign actual_taken = (PCSrcE != PC_PLUS4);

  // JALR is never allocated, so it only escapes a redirect if the carried
  // prediction happens to be taken with the exact resolved target.
  always_comb begin
    mispred = 1'b0;
    if (is_jalr) begin
      mispred = !predTakenE || (predTargetE != targetE);
    end else begin
      mispred = (predTakenE != actual_taken) ||
                (actual_taken && (predTargetE != targetE));
    end
  end

  assign redirectE   = active && mispred;
  assign redirectPCE = actual_taken ? targetE : pcE + XLEN'(4);

  // ---------------- Table update ----------------
  logic [INDEX_BITS-1:0] idx_e;
  logic [TAG_BITS-1:0]   tag_e;
  btb_entry_t            entry_e, upd_entry;
  logic                  hit_e, upd_active, upd_en;
  logic [1:0]            ctr_next;

  assign idx_e      = pcE[INDEX_BITS+1:2];
  assign tag_e      = pcE[XLEN-1:INDEX_BITS+2];
  assign entry_e    = btb_q[idx_e];
  assign hit_e      = entry_e.valid && (entry_e.tag == tag_e);
  assign upd_active = active && !is_jalr;

  bp_sat_counter u_sat (
    .ctr_i   (entry_e.ctr),
    .taken_i (actual_taken),
    .ctr_o   (ctr_next)
  );

  always_comb begin
    upd_en    = 1'b0;
    upd_entry = entry_e;
    if (upd_active) begin
      if (hit_e) begin
        upd_en        = 1'b1;
        upd_entry.ctr = ctr_t'(ctr_next);
        if (actual_taken) upd_entry.target = targetE;
      end else if (actual_taken) begin
        // Taken miss evicts whatever aliases to this index.
        upd_en    = 1'b1;
        upd_entry = '{valid: 1'b1, tag: tag_e, target: targetE, ctr: WEAK_T};
      end
    end
  end

  assign branch_cnt_d  = branch_cnt_q + {31'd0, active};
  assign mispred_cnt_d = mispred_cnt_q + {31'd0, redirectE};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WEAK_NT};
      end
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (upd_en) btb_q[idx_e] <= upd_entry;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branchCount  = branch_cnt_q;
  assign mispredCount = mispred_cnt_q;

endmodule
